// File: rtl/stack_cpu_pkg.sv
// Shared encodings for the 8-bit stack-machine CPU: opcodes, ALU operations,
// datapath mux selects, control-word layout and controller state encoding.
package stack_cpu_pkg;

    // Opcodes carried in IR[7:5]
    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_SUB  = 3'b001;
    localparam logic [2:0] OPC_AND  = 3'b010;
    localparam logic [2:0] OPC_NOT  = 3'b011;
    localparam logic [2:0] OPC_PUSH = 3'b100;
    localparam logic [2:0] OPC_POP  = 3'b101;
    localparam logic [2:0] OPC_JMP  = 3'b110;
    localparam logic [2:0] OPC_JZ   = 3'b111;

    // ALU operations; the ALU opcodes equal opc[1:0] of the ALU instructions
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTA = 2'b11;

    // SrcA select
    localparam logic [1:0] S1_A     = 2'd0;
    localparam logic [1:0] S1_PC    = 2'd1;
    localparam logic [1:0] S1_OLDPC = 2'd2;

    // SrcB select
    localparam logic [1:0] S2_B     = 2'd0;
    localparam logic [1:0] S2_ONE   = 2'd1;
    localparam logic [1:0] S2_BUS5  = 2'd2;

    // bus5 select
    localparam logic [1:0] B5_IR     = 2'd0;
    localparam logic [1:0] B5_ALUREG = 2'd1;
    localparam logic [1:0] B5_ALURES = 2'd2;

    // bus8 select
    localparam logic [1:0] B8_RDATA  = 2'd0;
    localparam logic [1:0] B8_STACK  = 2'd1;
    localparam logic [1:0] B8_ALURES = 2'd2;

    // Controller state encoding; FETCH must stay 0 (visible on state_dbg in reset)
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_POP_B  = 4'd2,
        ST_POP_A  = 4'd3,
        ST_ALU_WB = 4'd4,
        ST_PUSH_M = 4'd5,
        ST_POP_M  = 4'd6,
        ST_JUMP   = 4'd7,
        ST_JZ     = 4'd8
    } state_t;

    // Full control word driven to the datapath
    typedef struct packed {
        logic       push;
        logic       pop;
        logic       ir_write;
        logic       en2;
        logic       en3;
        logic       write_en;
        logic       pc_write;
        logic       old_pc_write;
        logic       adr_src;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [1:0] bus5_src;
        logic [1:0] bus8_src;
        logic [1:0] alu_control;
        logic       instr_done;
    } ctl_t;

    // ALU-class instructions that consume two stack operands
    function automatic logic is_binary_alu(input logic [2:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_AND);
    endfunction

endpackage

// File: rtl/stack_ctrl_fsm_if.sv
// Control/status bundle between the stack-CPU controller and its datapath.
interface stack_ctrl_fsm_if;
    logic [2:0] opc;
    logic       Zero;
    logic       push;
    logic       pop;
    logic       IR_write;
    logic       en2;
    logic       en3;
    logic       write_en;
    logic       pc_write;
    logic       old_pc_write;
    logic       adr_src;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] bus5_src;
    logic [1:0] bus8_src;
    logic [1:0] ALU_control;
    logic       instr_done;
    logic [3:0] state_dbg;

    // Controller side
    modport master (
        input  opc, Zero,
        output push, pop, IR_write, en2, en3, write_en, pc_write, old_pc_write,
               adr_src, s1, s2, bus5_src, bus8_src, ALU_control, instr_done, state_dbg
    );

    // Datapath side
    modport slave (
        output opc, Zero,
        input  push, pop, IR_write, en2, en3, write_en, pc_write, old_pc_write,
               adr_src, s1, s2, bus5_src, bus8_src, ALU_control, instr_done, state_dbg
    );
endinterface

// File: rtl/stack_ctrl_fsm.sv
// Multicycle controller for the 8-bit stack machine: fetch, decode, execute
// and write-back of one instruction at a time.
module stack_ctrl_fsm
    import stack_cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    stack_ctrl_fsm_if.master bus
);

    state_t r_state;
    state_t w_next_state;
    ctl_t   w_ctl;

    // State register, asynchronously returned to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection
    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_FETCH:  w_next_state = ST_DECODE;
            ST_DECODE: begin
                case (bus.opc)
                    OPC_ADD, OPC_SUB, OPC_AND: w_next_state = ST_POP_B;
                    OPC_NOT:                   w_next_state = ST_POP_A;
                    OPC_PUSH:                  w_next_state = ST_PUSH_M;
                    OPC_POP:                   w_next_state = ST_POP_M;
                    OPC_JMP:                   w_next_state = ST_JUMP;
                    default:                   w_next_state = ST_JZ;
                endcase
            end
            ST_POP_B:  w_next_state = ST_POP_A;
            ST_POP_A:  w_next_state = ST_ALU_WB;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // Control-word decode from state (plus Zero in JZ); all zero while in reset
    always_comb begin
        w_ctl = '0;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    w_ctl.adr_src      = 1'b0;
                    w_ctl.bus8_src     = B8_RDATA;
                    w_ctl.ir_write     = 1'b1;
                    w_ctl.s1           = S1_PC;
                    w_ctl.s2           = S2_ONE;
                    w_ctl.alu_control  = ALU_ADD;
                    w_ctl.bus5_src     = B5_ALURES;
                    w_ctl.pc_write     = 1'b1;
                    w_ctl.old_pc_write = 1'b1;
                end
                ST_POP_B: begin
                    w_ctl.bus8_src = B8_STACK;
                    w_ctl.en2      = 1'b1;
                    w_ctl.pop      = 1'b1;
                end
                ST_POP_A: begin
                    w_ctl.bus8_src = B8_STACK;
                    w_ctl.en3      = 1'b1;
                    w_ctl.pop      = 1'b1;
                end
                ST_ALU_WB: begin
                    w_ctl.s1          = S1_A;
                    w_ctl.s2          = S2_B;
                    w_ctl.alu_control = bus.opc[1:0];
                    w_ctl.bus8_src    = B8_ALURES;
                    w_ctl.push        = 1'b1;
                    w_ctl.instr_done  = 1'b1;
                end
                ST_PUSH_M: begin
                    w_ctl.adr_src    = 1'b1;
                    w_ctl.bus5_src   = B5_IR;
                    w_ctl.bus8_src   = B8_RDATA;
                    w_ctl.push       = 1'b1;
                    w_ctl.instr_done = 1'b1;
                end
                ST_POP_M: begin
                    w_ctl.adr_src    = 1'b1;
                    w_ctl.bus5_src   = B5_IR;
                    w_ctl.bus8_src   = B8_STACK;
                    w_ctl.write_en   = 1'b1;
                    w_ctl.pop        = 1'b1;
                    w_ctl.instr_done = 1'b1;
                end
                ST_JUMP: begin
                    w_ctl.bus5_src   = B5_IR;
                    w_ctl.pc_write   = 1'b1;
                    w_ctl.instr_done = 1'b1;
                end
                ST_JZ: begin
                    w_ctl.bus5_src   = B5_IR;
                    w_ctl.pc_write   = bus.Zero;
                    w_ctl.instr_done = 1'b1;
                end
                default: w_ctl = '0;
            endcase
        end
    end

    assign bus.push         = w_ctl.push;
    assign bus.pop          = w_ctl.pop;
    assign bus.IR_write     = w_ctl.ir_write;
    assign bus.en2          = w_ctl.en2;
    assign bus.en3          = w_ctl.en3;
    assign bus.write_en     = w_ctl.write_en;
    assign bus.pc_write     = w_ctl.pc_write;
    assign bus.old_pc_write = w_ctl.old_pc_write;
    assign bus.adr_src      = w_ctl.adr_src;
    assign bus.s1           = w_ctl.s1;
    assign bus.s2           = w_ctl.s2;
    assign bus.bus5_src     = w_ctl.bus5_src;
    assign bus.bus8_src     = w_ctl.bus8_src;
    assign bus.ALU_control  = w_ctl.alu_control;
    assign bus.instr_done   = w_ctl.instr_done;
    assign bus.state_dbg    = reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_stack_ctrl_fsm.sv
// Self-checking bench for stack_ctrl_fsm: directed scenarios plus a random
// instruction stream, compared against a per-instruction cycle-table model.
module tb_stack_ctrl_fsm;
    import stack_cpu_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   instr_cnt;
    int   done_cnt;

    stack_ctrl_fsm_if u_if ();

    stack_ctrl_fsm u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles per instruction class
    function automatic int lat_of(input logic [2:0] op);
        if (op <= 3'd2) return 5;
        if (op == 3'd3) return 4;
        return 3;
    endfunction

    // Expected control word for cycle c (0 = fetch) of instruction op
    function automatic ctl_t exp_ctl(input logic [2:0] op, input int c, input logic z);
        ctl_t e;
        int   lat;
        e   = '0;
        lat = lat_of(op);
        if (c == 0) begin
            e.ir_write = 1'b1; e.s1 = 2'd1; e.s2 = 2'd1; e.bus5_src = 2'd2;
            e.pc_write = 1'b1; e.old_pc_write = 1'b1;
        end else if (c == 1) begin
            e = '0;
        end else if (c == lat - 1) begin
            e.instr_done = 1'b1;
            case (op)
                3'd4: begin e.adr_src = 1'b1; e.push = 1'b1; end
                3'd5: begin e.adr_src = 1'b1; e.bus8_src = 2'd1; e.write_en = 1'b1; e.pop = 1'b1; end
                3'd6: e.pc_write = 1'b1;
                3'd7: e.pc_write = z;
                default: begin e.alu_control = op[1:0]; e.bus8_src = 2'd2; e.push = 1'b1; end
            endcase
        end else if (c == lat - 2) begin
            e.bus8_src = 2'd1; e.en3 = 1'b1; e.pop = 1'b1;
        end else begin
            e.bus8_src = 2'd1; e.en2 = 1'b1; e.pop = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [3:0] exp_state(input logic [2:0] op, input int c);
        int lat;
        lat = lat_of(op);
        if (c == 0) return ST_FETCH;
        if (c == 1) return ST_DECODE;
        if (c == lat - 1) begin
            case (op)
                3'd4:    return ST_PUSH_M;
                3'd5:    return ST_POP_M;
                3'd6:    return ST_JUMP;
                3'd7:    return ST_JZ;
                default: return ST_ALU_WB;
            endcase
        end
        if (c == lat - 2) return ST_POP_A;
        return ST_POP_B;
    endfunction

    function automatic ctl_t get_act();
        ctl_t a;
        a.push = u_if.push; a.pop = u_if.pop; a.ir_write = u_if.IR_write;
        a.en2 = u_if.en2; a.en3 = u_if.en3; a.write_en = u_if.write_en;
        a.pc_write = u_if.pc_write; a.old_pc_write = u_if.old_pc_write;
        a.adr_src = u_if.adr_src; a.s1 = u_if.s1; a.s2 = u_if.s2;
        a.bus5_src = u_if.bus5_src; a.bus8_src = u_if.bus8_src;
        a.alu_control = u_if.ALU_control; a.instr_done = u_if.instr_done;
        return a;
    endfunction

    // Runs one instruction starting just after the edge that entered FETCH.
    // zmode: 0/1 = hold Zero at that value, 2 = random Zero every cycle.
    task automatic run_instr(input logic [2:0] op, input int zmode);
        int   lat;
        int   done_at;
        logic z;
        ctl_t act;
        ctl_t exp;
        logic pc_ok;
        lat     = lat_of(op);
        done_at = -1;
        for (int c = 0; c < lat; c++) begin
            u_if.opc  = (c == 0) ? 3'($urandom_range(0, 7)) : op;
            z         = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            u_if.Zero = z;
            @(negedge clk);
            act = get_act();
            exp = exp_ctl(op, c, z);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL ctl op=%0d cyc=%0d: got %h expected %h", op, c, act, exp);
            end
            checks++;
            if (u_if.state_dbg !== exp_state(op, c)) begin
                errors++;
                $display("FAIL state op=%0d cyc=%0d: got %0d expected %0d",
                         op, c, u_if.state_dbg, exp_state(op, c));
            end
            checks++;
            if (act.push && act.pop) begin
                errors++;
                $display("FAIL push_pop op=%0d cyc=%0d: got 1 expected 0", op, c);
            end
            checks++;
            if (act.write_en && act.ir_write) begin
                errors++;
                $display("FAIL we_irw op=%0d cyc=%0d: got 1 expected 0", op, c);
            end
            pc_ok = (c == 0) || ((c == lat - 1) && (op == 3'd6 || (op == 3'd7 && z)));
            checks++;
            if (act.pc_write && !pc_ok) begin
                errors++;
                $display("FAIL pc_write op=%0d cyc=%0d: got 1 expected 0", op, c);
            end
            if (act.instr_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            @(posedge clk);
            #1;
        end
        instr_cnt++;
        checks++;
        if (done_at != lat - 1) begin
            errors++;
            $display("FAIL latency op=%0d: got %0d expected %0d", op, done_at + 1, lat);
        end
    endtask

    task automatic test_reset();
        ctl_t act;
        reset = 1'b1;
        u_if.opc = 3'd0;
        u_if.Zero = 1'b0;
        #3;
        act = get_act();
        checks++;
        if (act !== '0 || u_if.state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL reset_init: got %h/%0d expected 0/0", act, u_if.state_dbg);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        ctl_t act;
        u_if.opc = 3'd0;
        u_if.Zero = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (u_if.state_dbg !== ST_POP_A) begin
            errors++;
            $display("FAIL reach_pop_a: got %0d expected %0d", u_if.state_dbg, ST_POP_A);
        end
        reset = 1'b1;
        #1;
        act = get_act();
        checks++;
        if (act !== '0 || u_if.state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h/%0d expected 0/0", act, u_if.state_dbg);
        end
        @(posedge clk);
        #1;
        act = get_act();
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 0", act);
        end
        reset = 1'b0;
        #1;
        act = get_act();
        checks++;
        if (act !== exp_ctl(3'd0, 0, 1'b0) || u_if.state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: got %h/%0d expected %h/0",
                     act, u_if.state_dbg, exp_ctl(3'd0, 0, 1'b0));
        end
    endtask

    task automatic test_add();
        run_instr(3'd0, 2);
    endtask

    task automatic test_not();
        run_instr(3'd3, 2);
    endtask

    task automatic test_pop();
        run_instr(3'd5, 2);
    endtask

    task automatic test_jz();
        run_instr(3'd7, 1);
        run_instr(3'd7, 0);
    endtask

    task automatic test_all_ops();
        for (int op = 0; op < 8; op++) run_instr(3'(op), 2);
    endtask

    task automatic test_random_stream();
        int start_instr;
        int start_done;
        start_instr = instr_cnt;
        start_done  = done_cnt;
        for (int i = 0; i < 200; i++) run_instr(3'($urandom_range(0, 7)), 2);
        checks++;
        if ((done_cnt - start_done) != (instr_cnt - start_instr)) begin
            errors++;
            $display("FAIL done_count: got %0d expected %0d",
                     done_cnt - start_done, instr_cnt - start_instr);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        instr_cnt = 0;
        done_cnt  = 0;
        test_reset();
        test_reset_mid();
        test_add();
        test_not();
        test_pop();
        test_jz();
        test_all_ops();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so a stuck design still ends the run
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/stack_ctrl_fsm.md
Name: stack_ctrl_fsm

Overview:
- Multicycle control unit for the 8-bit stack-machine datapath.
- Consumes the opcode (IR[7:5]) and the stack-top Zero flag.
- Drives every enable and mux select of the datapath: fetch, decode, execute and write-back of one instruction at a time.
- Sits beside the datapath inside the CPU top level; the shared memory holds both program and data.

Parameters:
- None. All opcode, ALU and mux-select encodings are fixed constants in the shared package.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opc  input  3  opcode from IR[7:5]; valid from the DECODE cycle onward.
- Zero  input  1  1 when stack top == 0.
- push  output  1  stack push of bus8.
- pop  output  1  stack pop.
- IR_write  output  1  IR load from bus8.
- en2  output  1  B register load.
- en3  output  1  A register load.
- write_en  output  1  data memory write.
- pc_write  output  1  PC load from bus5.
- old_pc_write  output  1  old_PC load from PC.
- adr_src  output  1  memory address select: 0 = PC, 1 = bus5.
- s1  output  2  SrcA select: 0 = A, 1 = PC, 2 = old_PC.
- s2  output  2  SrcB select: 0 = B, 1 = const 1, 2 = bus5.
- bus5_src  output  2  bus5 select: 0 = IR[4:0], 1 = ALU_reg[4:0], 2 = ALUResult[4:0].
- bus8_src  output  2  bus8 select: 0 = ReadData, 1 = stack top, 2 = ALUResult.
- ALU_control  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 NOT A.
- instr_done  output  1  high in the final cycle of each instruction.
- state_dbg  output  4  current state encoding, for the bench.

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr. addr = IR[4:0].
- State register is updated on the rising clk edge; reset asynchronously forces FETCH.
- While reset = 1, every output is forced to 0. This includes state_dbg = FETCH encoding 0.
- Outputs are decoded from state only, except in JZ, which depends on Zero. Any signal not listed for a state is 0.
- FETCH:
  - adr_src=0, bus8_src=0, IR_write=1, s1=1, s2=1, ALU_control=00, bus5_src=2, pc_write=1, old_pc_write=1.
  - At the edge, old_PC takes the pre-increment PC and PC takes PC+1.
  - Next state: DECODE.
- DECODE:
  - All outputs 0.
  - Next state: ADD/SUB/AND -> POP_B; NOT -> POP_A; PUSH -> PUSH_M; POP -> POP_M; JMP -> JUMP; JZ -> JZ.
- POP_B: bus8_src=1, en2=1, pop=1. Next state: POP_A.
- POP_A: bus8_src=1, en3=1, pop=1. Next state: ALU_WB.
- ALU_WB:
  - s1=0, s2=0, ALU_control = opc[1:0], bus8_src=2, push=1, instr_done=1.
  - Next state: FETCH.
- PUSH_M: adr_src=1, bus5_src=0, bus8_src=0, push=1, instr_done=1. Next state: FETCH.
- POP_M: adr_src=1, bus5_src=0, bus8_src=1, write_en=1, pop=1, instr_done=1. Next state: FETCH.
- JUMP: bus5_src=0, pc_write=1, instr_done=1. Next state: FETCH.
- JZ:
  - bus5_src=0, pc_write=Zero, instr_done=1.
  - Stack is not popped.
  - Next state: FETCH.
- Latency in cycles: ADD/SUB/AND 5; NOT 4; PUSH, POP, JMP, JZ 3.
- Invariants:
  - push and pop are never high in the same cycle.
  - write_en and IR_write are never high in the same cycle.
  - pc_write is high only in FETCH, JUMP, and JZ with Zero=1.
- Operand order: A (second pop, deeper element) op B (first pop, top). SUB yields deeper − top.
- Zero is sampled combinationally during the JZ cycle only; changes on Zero in other states have no effect.
- Reset asserted mid-instruction: outputs drop to 0 immediately and the FSM returns to FETCH; no partial write completes after reset assertion.
- Unreachable state encodings: outputs 0, next state FETCH.

Decomposition:
- Package stack_cpu_pkg holds:
  - opcode localparams;
  - ALU_control codes;
  - mux-select codes for s1, s2, bus5_src, bus8_src;
  - the state enum typedef, 4 bits.
- No sub-module: a single FSM with a next-state block and an output-decode block.

Test Plan:
- Reset: assert reset mid-POP_A (state_dbg = POP_A encoding) -> all outputs 0 immediately. After release, first cycle shows IR_write=1, pc_write=1, s1=1, s2=1, bus5_src=2.
- ADD (opc=000): states FETCH, DECODE, POP_B, POP_A, ALU_WB.
  - en2 pulses in cycle 3; en3 in cycle 4.
  - Cycle 5 has push=1, bus8_src=2, ALU_control=00, instr_done=1.
  - Total 5 cycles, then FETCH.
- NOT (opc=011): 4 cycles; POP_B is skipped. ALU_WB has ALU_control=11 and push=1.
- POP addr (opc=101): cycle 3 has write_en=1, pop=1, adr_src=1, bus5_src=0, bus8_src=1. push=0 throughout.
- JZ (opc=111):
  - Zero=1 in cycle 3 -> pc_write=1, bus5_src=0.
  - Repeat with Zero=0 -> pc_write=0 and instr_done=1.
  - pop=0 in both runs.
- Random opcode stream of 200 instructions:
  - never push and pop together;
  - never write_en and IR_write together;
  - instr_done count equals instruction count;
  - per-opcode latency matches 5/4/3.
